// File: rtl/fa_exhaustive_checker.sv
// Exhaustive response checker for the 1-bit full adder: sweeps all eight
// {ci,x,y} vectors, waits SETTLE cycles per vector, compares co/s against
// the arithmetic reference and accumulates a pass/fail verdict.
module fa_exhaustive_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ci,
  output logic       x,
  output logic       y,
  input  logic       co,
  input  logic       s,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 4;
  localparam int unsigned VEC_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [VEC_W-1:0]   k;
  logic [CNT_W-1:0]   cnt;

  logic               exp_co;
  logic               exp_s;
  logic               mismatch;
  logic [ERR_W-1:0]   err_next;

  // Reference response for the current vector; X/Z on co/s counts as a mismatch.
  always_comb begin
    exp_co   = (k[2] & k[1]) | (k[2] & k[0]) | (k[1] & k[0]);
    exp_s    = ^k;
    mismatch = !((co === exp_co) && (s === exp_s));
    err_next = err_count + ERR_W'(mismatch);
  end

  // Sweep sequencer with registered stimulus and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      k                <= '0;
      cnt              <= '0;
      ci               <= 1'b0;
      x                <= 1'b0;
      y                <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= APPLY;
            k                <= '0;
            cnt              <= CNT_W'(SETTLE);
            {ci, x, y}       <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        end
        APPLY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Sample cycle: fold this vector into the results.
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= k;
            end
            if (k == VEC_W'(7)) begin
              state      <= DONE;
              {ci, x, y} <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= (err_next == '0);
            end else begin
              k          <= k + VEC_W'(1);
              {ci, x, y} <= k + VEC_W'(1);
              cnt        <= CNT_W'(SETTLE);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// Bench for fa_exhaustive_checker: three checker instances (SETTLE 2/0/1)
// each driving a behavioural full adder with a selectable fault.
module tb_fa_exhaustive_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst;
  logic [2:0] st;
  logic [2:0] ci_w, x_w, y_w, co_w, s_w, busy_w, done_w, pass_w, ffv_w;
  logic [3:0] err_w [3];
  logic [2:0] ffvec_w [3];
  int         fault [3];   // 0 = good adder, 1 = co inverted, 2 = s stuck at 0

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int         inst;
    logic [3:0] err;
    logic       ffv;
    logic [2:0] ffvec;
    logic       pass;
    int         done_cyc;
  } exp_t;

  exp_t sbq[$];

  // Behavioural full adder with fault injection.
  function automatic logic [1:0] fa_ref(input logic [2:0] v, input int f);
    logic c, sm;
    c  = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    sm = ^v;
    if (f == 1) c = ~c;
    if (f == 2) sm = 1'b0;
    return {c, sm};
  endfunction

  assign {co_w[0], s_w[0]} = fa_ref({ci_w[0], x_w[0], y_w[0]}, fault[0]);
  assign {co_w[1], s_w[1]} = fa_ref({ci_w[1], x_w[1], y_w[1]}, fault[1]);
  assign {co_w[2], s_w[2]} = fa_ref({ci_w[2], x_w[2], y_w[2]}, fault[2]);

  fa_exhaustive_checker #(.SETTLE(2)) u_s2 (
    .clk(clk), .rst(rst), .start(st[0]),
    .ci(ci_w[0]), .x(x_w[0]), .y(y_w[0]), .co(co_w[0]), .s(s_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
    .first_fail_valid(ffv_w[0]), .first_fail_vec(ffvec_w[0])
  );

  fa_exhaustive_checker #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(st[1]),
    .ci(ci_w[1]), .x(x_w[1]), .y(y_w[1]), .co(co_w[1]), .s(s_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
    .first_fail_valid(ffv_w[1]), .first_fail_vec(ffvec_w[1])
  );

  fa_exhaustive_checker #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(st[2]),
    .ci(ci_w[2]), .x(x_w[2]), .y(y_w[2]), .co(co_w[2]), .s(s_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]),
    .first_fail_valid(ffv_w[2]), .first_fail_vec(ffvec_w[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // All outputs of one instance packed for reset checks.
  function automatic logic [31:0] outs(input int i);
    return 32'({ci_w[i], x_w[i], y_w[i], busy_w[i], done_w[i], pass_w[i],
                err_w[i], ffv_w[i], ffvec_w[i]});
  endfunction

  function automatic logic [31:0] vec(input int i);
    return 32'({ci_w[i], x_w[i], y_w[i]});
  endfunction

  task automatic push_exp(input int inst, input int err, input logic ffv,
                          input logic [2:0] ffvec, input logic pass, input int dc);
    exp_t e;
    e.inst = inst; e.err = 4'(err); e.ffv = ffv; e.ffvec = ffvec;
    e.pass = pass; e.done_cyc = dc;
    sbq.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_results", 32'(sbq.size()), 0);
  endtask

  // Monitor: on each rising done, pop and compare the expected verdict.
  logic [2:0] done_q = '0;
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] === 1'b1 && done_q[i] !== 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: inst %0d raised done with no expected result queued", i);
        end else begin
          e = sbq.pop_front();
          check("sb_inst", 32'(i), 32'(e.inst));
          check("sb_err_count", 32'(err_w[i]), 32'(e.err));
          check("sb_first_fail_valid", 32'(ffv_w[i]), 32'(e.ffv));
          if (e.ffv) check("sb_first_fail_vec", 32'(ffvec_w[i]), 32'(e.ffvec));
          check("sb_pass", 32'(pass_w[i]), 32'(e.pass));
          check("sb_busy_low", 32'(busy_w[i]), 0);
          check("sb_done_cycle", 32'(cyc), 32'(e.done_cyc));
        end
      end
    end
    done_q = done_w;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    st  = '0;
    for (int i = 0; i < 3; i++) fault[i] = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check("reset_outputs", outs(i), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good adder, SETTLE=2, with an ignored start pulse mid-sweep.
    t = cyc;
    st[0] = 1'b1;
    push_exp(0, 0, 1'b0, 3'd0, 1'b1, t + 25);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      check("a_busy", 32'(busy_w[0]), 1);
      check("a_done_low", 32'(done_w[0]), 0);
      check("a_vector", vec(0), 32'((c - 1) / 3));
      if (c == 1)  st[0] = 1'b0;
      if (c == 10) st[0] = 1'b1;
      if (c == 11) st[0] = 1'b0;
    end
    @(negedge clk);
    check("a_vector_done", vec(0), 0);
    wait_drain();

    // s stuck at 0, SETTLE=0: vectors 1,2,4,7 fail.
    fault[1] = 2;
    @(negedge clk);
    t = cyc;
    st[1] = 1'b1;
    push_exp(1, 4, 1'b1, 3'b001, 1'b0, t + 9);
    @(negedge clk);
    st[1] = 1'b0;
    wait_drain();

    // co inverted, SETTLE=1: every vector fails.
    fault[2] = 1;
    @(negedge clk);
    t = cyc;
    st[2] = 1'b1;
    push_exp(2, 8, 1'b1, 3'b000, 1'b0, t + 17);
    @(negedge clk);
    st[2] = 1'b0;
    wait_drain();

    // Restart from DONE after a failing run clears results immediately.
    fault[1] = 0;
    @(negedge clk);
    t = cyc;
    st[1] = 1'b1;
    push_exp(1, 0, 1'b0, 3'd0, 1'b1, t + 9);
    @(negedge clk);
    check("d_done_drop", 32'(done_w[1]), 0);
    check("d_err_clear", 32'(err_w[1]), 0);
    check("d_ffv_clear", 32'(ffv_w[1]), 0);
    check("d_busy", 32'(busy_w[1]), 1);
    st[1] = 1'b0;
    wait_drain();

    // Reset while vector 3 is applied, then a clean sweep.
    @(negedge clk);
    t = cyc;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (9) @(negedge clk);
    check("e_vector3", vec(0), 3);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check("e_reset_outputs", outs(i), 0);
    rst = 1'b0;
    @(negedge clk);
    check("e_stays_idle", outs(0), 0);
    t = cyc;
    st[0] = 1'b1;
    push_exp(0, 0, 1'b0, 3'd0, 1'b1, t + 25);
    @(negedge clk);
    st[0] = 1'b0;
    wait_drain();

    // start held high: back-to-back sweeps, done high one cycle between.
    @(negedge clk);
    t = cyc;
    st[0] = 1'b1;
    push_exp(0, 0, 1'b0, 3'd0, 1'b1, t + 25);
    push_exp(0, 0, 1'b0, 3'd0, 1'b1, t + 50);
    push_exp(0, 0, 1'b0, 3'd0, 1'b1, t + 75);
    repeat (25) @(negedge clk);
    check("f_done1", 32'(done_w[0]), 1);
    check("f_pass1", 32'(pass_w[0]), 1);
    @(negedge clk);
    check("f_done1_one_cycle", 32'(done_w[0]), 0);
    check("f_busy_again", 32'(busy_w[0]), 1);
    repeat (24) @(negedge clk);
    check("f_done2", 32'(done_w[0]), 1);
    @(negedge clk);
    check("f_done2_one_cycle", 32'(done_w[0]), 0);
    st[0] = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("f_done_holds", 32'(done_w[0]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
